bram_fill_ctrl: RTL and testbench

// Write-side controller for one L2 write channel of the multi-stream BRAM buffer.
// - Accepts memory-response beats tagged {stream, cache line} and assembles them

---
 rtl/msb_pkg.sv | 25 ++
 rtl/base_areg.sv | 35 +++
 rtl/bram_fill_ctrl.sv | 138 +++++++++++++
 tb/tb_bram_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msb_pkg.sv
// Shared definitions for the multi-stream BRAM buffer: stream / cache-line
// tag types, the line tag struct and the BRAM write-address packing.
// Used by bram_fill_ctrl, bram_top and the stream tracker.
package msb_pkg;

    localparam int L1_NSTRMS       = 16;
    localparam int L1_NCL          = 16;
    localparam int L1_NSTRMS_WIDTH = $clog2(L1_NSTRMS);
    localparam int L1_NCL_WIDTH    = $clog2(L1_NCL);
    localparam int WA_WIDTH        = L1_NSTRMS_WIDTH + L1_NCL_WIDTH + 1;

    typedef logic [L1_NSTRMS_WIDTH-1:0] st_t;
    typedef logic [L1_NCL_WIDTH-1:0]    cl_t;

    typedef struct packed {
        st_t st;
        cl_t cl;
    } line_tag_t;

    // BRAM row of one half line: {stream, cache line, half}
    function automatic logic [WA_WIDTH-1:0] wa(input line_tag_t tag, input logic half);
        return {tag.st, tag.cl, half};
    endfunction

endpackage

// File: rtl/base_areg.sv
// Single-entry valid/ready output register.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   src_v/src_r/src_d  upstream side; src_r = slot empty or being drained
//   dst_v/dst_r/dst_d  downstream side; dst_d is stable while dst_v & !dst_r
module base_areg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_v,
    output logic             src_r,
    input  logic [WIDTH-1:0] src_d,
    output logic             dst_v,
    input  logic             dst_r,
    output logic [WIDTH-1:0] dst_d
);

    assign src_r = !dst_v || dst_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_v <= 1'b0;
        end else if (src_r) begin
            dst_v <= src_v;
        end
    end

    always_ff @(posedge clk) begin
        if (src_v && src_r) begin
            dst_d <= src_d;
        end
    end

endmodule

// File: rtl/bram_fill_ctrl.sv
// Write-side controller for one L2 write channel of the multi-stream BRAM
// buffer. Assembles tagged response beats into half-line words, writes each
// half to the BRAM and posts one fill-complete notification per line.
// Ports:
//   clk1x, reset           clock, synchronous active-high reset
//   i_v/i_r                response beat handshake
//   i_st/i_cl/i_d          beat stream tag, cache-line tag, data
//   o_we/o_wa/o_wd         BRAM write port, address {st, cl, half}
//   o_fill_v/o_fill_r      fill-complete handshake
//   o_fill_st/o_fill_cl    tag of the completed line
//   o_err                  sticky tag-mismatch error
module bram_fill_ctrl
    import msb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WAYS       = 8,
    parameter int RAM_DEPTH  = 512,
    parameter int BEAT_WIDTH = 256,
    parameter int l1_nstrms  = 16,
    parameter int l1_ncl     = 16,
    localparam int ADDR_WIDTH      = $clog2(RAM_DEPTH),
    localparam int l1_nstrms_width = $clog2(l1_nstrms),
    localparam int l1_ncl_width    = $clog2(l1_ncl),
    localparam int HALF_WIDTH      = WAYS * DATA_WIDTH
) (
    input  logic                       clk1x,
    input  logic                       reset,
    input  logic                       i_v,
    output logic                       i_r,
    input  logic [l1_nstrms_width-1:0] i_st,
    input  logic [l1_ncl_width-1:0]    i_cl,
    input  logic [BEAT_WIDTH-1:0]      i_d,
    output logic                       o_we,
    output logic [ADDR_WIDTH-1:0]      o_wa,
    output logic [HALF_WIDTH-1:0]      o_wd,
    output logic                       o_fill_v,
    input  logic                       o_fill_r,
    output logic [l1_nstrms_width-1:0] o_fill_st,
    output logic [l1_ncl_width-1:0]    o_fill_cl,
    output logic                       o_err
);

    localparam int BPH = HALF_WIDTH / BEAT_WIDTH;
    localparam int BPL = 2 * BPH;
    localparam int BCW = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int SLW = (BPH > 1) ? $clog2(BPH) : 1;

    if (l1_nstrms_width + l1_ncl_width + 1 != ADDR_WIDTH) begin : g_chk_addr
        $error("bram_fill_ctrl: stream + line + half bits must equal ADDR_WIDTH");
    end
    if (BPH < 1 || (HALF_WIDTH % BEAT_WIDTH) != 0) begin : g_chk_beat
        $error("bram_fill_ctrl: BEAT_WIDTH must divide WAYS*DATA_WIDTH");
    end
    if (l1_nstrms_width != $bits(st_t) || l1_ncl_width != $bits(cl_t)) begin : g_chk_tag
        $error("bram_fill_ctrl: tag widths disagree with msb_pkg");
    end
    if (ADDR_WIDTH != WA_WIDTH) begin : g_chk_wa
        $error("bram_fill_ctrl: ADDR_WIDTH disagrees with msb_pkg");
    end

    logic [BCW-1:0]                  bc;
    logic [BCW-1:0]                  eff_bc;
    logic [BCW-1:0]                  bc_nxt;
    logic [SLW-1:0]                  slot;
    logic                            half;
    line_tag_t                       tag;
    line_tag_t                       beat_tag;
    line_tag_t                       cur_tag;
    line_tag_t                       fill_tag;
    logic [BPH-1:0][BEAT_WIDTH-1:0]  hbuf;
    logic [BPH-1:0][BEAT_WIDTH-1:0]  hbuf_nxt;
    logic                            take;
    logic                            mism;
    logic                            complete;
    logic                            line_done;
    logic                            fill_ready;

    // A pending, unaccepted fill blocks new beats so a completing line can
    // always load the fill register.
    assign i_r      = !reset && fill_ready;
    assign beat_tag = {i_st, i_cl};

    always_comb begin
        take      = i_v && i_r;
        // A foreign tag mid-line abandons the current line and restarts at beat 0.
        mism      = take && (bc != '0) && (beat_tag != tag);
        eff_bc    = mism ? '0 : bc;
        cur_tag   = (eff_bc == '0) ? beat_tag : tag;
        half      = (eff_bc >= BCW'(BPH));
        slot      = SLW'(half ? (eff_bc - BCW'(BPH)) : eff_bc);
        hbuf_nxt       = hbuf;
        hbuf_nxt[slot] = i_d;
        complete  = take && ((eff_bc == BCW'(BPH - 1)) || (eff_bc == BCW'(BPL - 1)));
        line_done = take && (eff_bc == BCW'(BPL - 1));
        bc_nxt    = (eff_bc == BCW'(BPL - 1)) ? '0 : eff_bc + BCW'(1);
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            bc    <= '0;
            o_we  <= 1'b0;
            o_err <= 1'b0;
        end else begin
            o_we <= complete;
            if (mism) o_err <= 1'b1;
            if (take) bc <= bc_nxt;
        end
    end

    // Datapath only moves on an accepted beat, which never happens in reset.
    always_ff @(posedge clk1x) begin
        if (take) begin
            hbuf <= hbuf_nxt;
            if (eff_bc == '0) tag <= beat_tag;
        end
        if (complete) begin
            o_wa <= wa(cur_tag, half);
            o_wd <= hbuf_nxt;
        end
    end

    base_areg #(
        .WIDTH (l1_nstrms_width + l1_ncl_width)
    ) u_fill_reg (
        .clk   (clk1x),
        .reset (reset),
        .src_v (line_done),
        .src_r (fill_ready),
        .src_d (cur_tag),
        .dst_v (o_fill_v),
        .dst_r (o_fill_r),
        .dst_d (fill_tag)
    );

    assign o_fill_st = fill_tag.st;
    assign o_fill_cl = fill_tag.cl;

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// Directed + randomized bench for bram_fill_ctrl.
module tb_bram_fill_ctrl;

    localparam int DW    = 64;
    localparam int WAYS  = 8;
    localparam int DEPTH = 512;
    localparam int BW    = 256;
    localparam int HW    = WAYS * DW;
    localparam int BPL   = 4;

    typedef logic [BW-1:0] line_t [BPL];
    typedef struct {
        logic [8:0]    wa;
        logic [HW-1:0] wd;
    } wr_t;

    logic          clk1x = 1'b0;
    logic          reset = 1'b1;
    logic          i_v   = 1'b0;
    logic          i_r;
    logic [3:0]    i_st  = '0;
    logic [3:0]    i_cl  = '0;
    logic [BW-1:0] i_d   = '0;
    logic          o_we;
    logic [8:0]    o_wa;
    logic [HW-1:0] o_wd;
    logic          o_fill_v;
    logic          o_fill_r = 1'b1;
    logic [3:0]    o_fill_st;
    logic [3:0]    o_fill_cl;
    logic          o_err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    wr_t           wq[$];
    logic [7:0]    fq[$];
    logic [HW-1:0] mem     [0:DEPTH-1];
    logic [HW-1:0] exp_mem [0:DEPTH-1];

    bram_fill_ctrl #(
        .DATA_WIDTH (DW),
        .WAYS       (WAYS),
        .RAM_DEPTH  (DEPTH),
        .BEAT_WIDTH (BW),
        .l1_nstrms  (16),
        .l1_ncl     (16)
    ) dut (
        .clk1x     (clk1x),
        .reset     (reset),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_st      (i_st),
        .i_cl      (i_cl),
        .i_d       (i_d),
        .o_we      (o_we),
        .o_wa      (o_wa),
        .o_wd      (o_wd),
        .o_fill_v  (o_fill_v),
        .o_fill_r  (o_fill_r),
        .o_fill_st (o_fill_st),
        .o_fill_cl (o_fill_cl),
        .o_err     (o_err)
    );

    always #5 clk1x = ~clk1x;
    always @(posedge clk1x) cyc <= cyc + 1;

    // Write / fill monitor, sampled mid-cycle
    always @(negedge clk1x) begin
        if (o_we === 1'b1) begin
            wq.push_back('{o_wa, o_wd});
            mem[o_wa] <= o_wd;
        end
        if (o_fill_v === 1'b1 && o_fill_r === 1'b1) fq.push_back({o_fill_st, o_fill_cl});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk1x);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] st, input logic [3:0] cl,
                             input logic [BW-1:0] d, output int stalls);
        i_v = 1'b1; i_st = st; i_cl = cl; i_d = d; stalls = 0;
        forever begin
            @(negedge clk1x);
            if (i_r === 1'b1) break;
            stalls++;
            if (stalls > 200) begin
                n_cmp++; n_mis++;
                $display("FAIL beat_timeout: i_r=%b after %0d cycles, required 1", i_r, stalls);
                break;
            end
        end
        @(posedge clk1x);
        #1;
        i_v = 1'b0;
    endtask

    task automatic send_line(input logic [3:0] st, input logic [3:0] cl,
                             output line_t d, output int stalls);
        int s;
        stalls = 0;
        for (int k = 0; k < BPL; k++) begin
            d[k] = rnd_beat();
            send_beat(st, cl, d[k], s);
            stalls += s;
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [8:0] wa,
                          input logic [HW-1:0] wd);
        n_cmp++;
        if (idx >= wq.size()) begin
            n_mis++;
            $display("FAIL %s: write %0d missing (got %0d writes)", name, idx, wq.size());
        end else if (wq[idx].wa !== wa || wq[idx].wd !== wd) begin
            n_mis++;
            $display("FAIL %s: wa=%h wd[63:0]=%h, required wa=%h wd[63:0]=%h",
                     name, wq[idx].wa, wq[idx].wd[63:0], wa, wd[63:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; o_fill_r = 1'b1;
        tick(3);
        @(negedge clk1x);
        n_cmp++; if (o_we !== 1'b0)     begin n_mis++; $display("FAIL rst_we: %b required 0", o_we); end
        n_cmp++; if (o_fill_v !== 1'b0) begin n_mis++; $display("FAIL rst_fill_v: %b required 0", o_fill_v); end
        n_cmp++; if (o_err !== 1'b0)    begin n_mis++; $display("FAIL rst_err: %b required 0", o_err); end
        n_cmp++; if (i_r !== 1'b0)      begin n_mis++; $display("FAIL rst_ir: %b required 0", i_r); end
        tick(1);
        reset = 1'b0;
        @(negedge clk1x);
        n_cmp++; if (i_r !== 1'b1)      begin n_mis++; $display("FAIL rst_ir_release: %b required 1", i_r); end
        tick(1);
    endtask

    task automatic test_single_line();
        line_t d; int s;
        wq.delete(); fq.delete();
        send_line(4'd3, 4'd5, d, s);
        @(negedge clk1x);
        n_cmp++;
        if (o_we !== 1'b1 || o_wa !== 9'h06B || o_fill_v !== 1'b1) begin
            n_mis++;
            $display("FAIL single_latency: we=%b wa=%h fill_v=%b, required 1 06b 1", o_we, o_wa, o_fill_v);
        end
        @(negedge clk1x);
        n_cmp++;
        if (o_we !== 1'b0 || o_fill_v !== 1'b0) begin
            n_mis++;
            $display("FAIL single_pulse: we=%b fill_v=%b, required 0 0", o_we, o_fill_v);
        end
        tick(3);
        chk_wr("single_h0", 0, 9'h06A, {d[1], d[0]});
        chk_wr("single_h1", 1, 9'h06B, {d[3], d[2]});
        n_cmp++;
        if (wq.size() != 2 || fq.size() != 1 || fq[0] !== 8'h35) begin
            n_mis++;
            $display("FAIL single_counts: writes=%0d fills=%0d, required 2 1 (tag 35)", wq.size(), fq.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tags [4];
        line_t d [4];
        int s, tot, c0;
        tags[0] = 8'h12; tags[1] = 8'h13; tags[2] = 8'h7F; tags[3] = 8'h00;
        wq.delete(); fq.delete();
        tot = 0; c0 = cyc;
        for (int l = 0; l < 4; l++) begin
            send_line(tags[l][7:4], tags[l][3:0], d[l], s);
            tot += s;
        end
        n_cmp++; if (tot != 0) begin n_mis++; $display("FAIL b2b_stalls: %0d required 0", tot); end
        n_cmp++; if (cyc - c0 != 16) begin n_mis++; $display("FAIL b2b_cycles: %0d required 16", cyc - c0); end
        tick(3);
        n_cmp++;
        if (wq.size() != 8 || fq.size() != 4) begin
            n_mis++;
            $display("FAIL b2b_counts: writes=%0d fills=%0d, required 8 4", wq.size(), fq.size());
        end
        for (int l = 0; l < 4; l++) begin
            chk_wr("b2b_h0", 2*l,     {tags[l], 1'b0}, {d[l][1], d[l][0]});
            chk_wr("b2b_h1", 2*l + 1, {tags[l], 1'b1}, {d[l][3], d[l][2]});
            if (l < fq.size()) begin
                n_cmp++;
                if (fq[l] !== tags[l]) begin
                    n_mis++;
                    $display("FAIL b2b_fill_order: fill %0d tag=%h required %h", l, fq[l], tags[l]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        line_t da, db; int s, sb, bad;
        wq.delete(); fq.delete();
        o_fill_r = 1'b0;
        send_line(4'd3, 4'd5, da, s);
        bad = 0; sb = 0;
        fork
            send_line(4'd3, 4'd6, db, sb);
            begin
                repeat (5) begin
                    @(negedge clk1x);
                    if (o_fill_v !== 1'b1 || {o_fill_st, o_fill_cl} !== 8'h35 || i_r !== 1'b0) bad++;
                end
                @(posedge clk1x);
                #1;
                o_fill_r = 1'b1;
            end
        join
        tick(3);
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
        n_cmp++; if (sb != 5)  begin n_mis++; $display("FAIL bp_stalls: %0d required 5", sb); end
        chk_wr("bp_a_h1", 1, 9'h06B, {da[3], da[2]});
        chk_wr("bp_b_h0", 2, 9'h06C, {db[1], db[0]});
        chk_wr("bp_b_h1", 3, 9'h06D, {db[3], db[2]});
        n_cmp++;
        if (fq.size() != 2 || fq[0] !== 8'h35 || fq[1] !== 8'h36) begin
            n_mis++;
            $display("FAIL bp_fills: count=%0d, required 2 fills 35,36", fq.size());
        end
    endtask

    task automatic test_tag_change();
        logic [BW-1:0] d0, d1; line_t e; int s;
        wq.delete(); fq.delete();
        d0 = rnd_beat(); d1 = rnd_beat();
        send_beat(4'd3, 4'd5, d0, s);
        send_beat(4'd3, 4'd5, d1, s);
        send_line(4'd4, 4'd0, e, s);
        tick(3);
        n_cmp++; if (o_err !== 1'b1) begin n_mis++; $display("FAIL tag_err: %b required 1", o_err); end
        chk_wr("tag_old_h0", 0, 9'h06A, {d1, d0});
        chk_wr("tag_new_h0", 1, 9'h080, {e[1], e[0]});
        chk_wr("tag_new_h1", 2, 9'h081, {e[3], e[2]});
        n_cmp++;
        if (wq.size() != 3 || fq.size() != 1 || fq[0] !== 8'h40) begin
            n_mis++;
            $display("FAIL tag_counts: writes=%0d fills=%0d, required 3 1 (tag 40)", wq.size(), fq.size());
        end
    endtask

    task automatic test_reset_mid_line();
        line_t f; int s;
        wq.delete(); fq.delete();
        send_beat(4'd2, 4'd7, rnd_beat(), s);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk1x);
        n_cmp++;
        if (o_we !== 1'b0 || o_fill_v !== 1'b0 || o_err !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_state: we=%b fill_v=%b err=%b, required 0 0 0", o_we, o_fill_v, o_err);
        end
        tick(1);
        send_line(4'd2, 4'd7, f, s);
        tick(3);
        chk_wr("midrst_h0", 0, 9'h04E, {f[1], f[0]});
        chk_wr("midrst_h1", 1, 9'h04F, {f[3], f[2]});
        n_cmp++;
        if (wq.size() != 2 || fq.size() != 1 || fq[0] !== 8'h27 || o_err !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_counts: writes=%0d fills=%0d err=%b, required 2 1 0", wq.size(), fq.size(), o_err);
        end
    endtask

    task automatic test_random();
        localparam int NL = 20;
        logic [7:0] ltag [NL];
        line_t d; int s; bit done; int bad_fill, bad_mem;
        wq.delete(); fq.delete();
        done = 1'b0;
        fork
            begin
                for (int l = 0; l < NL; l++) begin
                    ltag[l] = 8'($urandom);
                    for (int k = 0; k < BPL; k++) begin
                        d[k] = rnd_beat();
                        send_beat(ltag[l][7:4], ltag[l][3:0], d[k], s);
                        if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2));
                    end
                    exp_mem[{ltag[l], 1'b0}] = {d[1], d[0]};
                    exp_mem[{ltag[l], 1'b1}] = {d[3], d[2]};
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk1x);
                    #2;
                    o_fill_r = 1'($urandom_range(0, 1));
                end
                o_fill_r = 1'b1;
            end
        join
        tick(6);
        n_cmp++;
        if (wq.size() != 2*NL || fq.size() != NL) begin
            n_mis++;
            $display("FAIL rnd_counts: writes=%0d fills=%0d, required %0d %0d", wq.size(), fq.size(), 2*NL, NL);
        end
        bad_fill = 0; bad_mem = 0;
        for (int l = 0; l < NL; l++) begin
            if (l >= fq.size() || fq[l] !== ltag[l]) bad_fill++;
            if (mem[{ltag[l], 1'b0}] !== exp_mem[{ltag[l], 1'b0}]) bad_mem++;
            if (mem[{ltag[l], 1'b1}] !== exp_mem[{ltag[l], 1'b1}]) bad_mem++;
        end
        n_cmp++; if (bad_fill != 0) begin n_mis++; $display("FAIL rnd_fills: %0d wrong, required 0", bad_fill); end
        n_cmp++; if (bad_mem != 0)  begin n_mis++; $display("FAIL rnd_mem: %0d wrong halves, required 0", bad_mem); end
        n_cmp++; if (o_err !== 1'b0) begin n_mis++; $display("FAIL rnd_err: %b required 0", o_err); end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_backpressure();
        test_tag_change();
        test_reset_mid_line();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
